// File: rtl/serial_alu_pkg.sv
// Shared types and sizing helpers for the bit-serial ALU engines.
package serial_alu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register, LSB presented first.
module piso_shift_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {1'b0, q[WIDTH-1:1]};
  end

  assign sout = q[0];

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract with NZCV flags, one bit per clock.
// Optional carry-in port enabled by defining SERIAL_ADDSUB_CIN_EN.
module serial_addsub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef SERIAL_ADDSUB_CIN_EN
  input  logic             cin,
`endif
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             carry, carry_msb, zero_acc;
  logic [WIDTH-1:0] res_sh;
  logic             a_bit, b_bit, s, cout;
  logic             accept, running, done, last, cin_init;

  assign accept  = start_valid && (state == S_IDLE);
  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign last    = (count == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDSUB_CIN_EN
  assign cin_init = cin;
`else
  assign cin_init = sub;
`endif

  piso_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .reset_n(reset_n), .load(accept), .shift(running),
    .d(a), .sout(a_bit)
  );

  // B is inverted at load so subtraction is A + ~B + 1 through the same cell.
  piso_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .reset_n(reset_n), .load(accept), .shift(running),
    .d(b ^ {WIDTH{sub}}), .sout(b_bit)
  );

  assign s    = a_bit ^ b_bit ^ carry;
  assign cout = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      count     <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      zero_acc  <= 1'b0;
      res_sh    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count     <= '0;
        carry     <= cin_init;
        carry_msb <= 1'b0;
        zero_acc  <= 1'b1;
        res_sh    <= '0;
      end else if (running) begin
        carry    <= cout;
        res_sh   <= {s, res_sh[WIDTH-1:1]};
        zero_acc <= zero_acc & ~s;
        if (last) carry_msb <= carry;
        else      count     <= count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_valid)  state_nxt = S_RUN;
      S_RUN:  if (last)         state_nxt = S_DONE;
      S_DONE: if (result_ready) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are gated so nothing leaks from the shift chain outside DONE.
  assign start_ready  = (state == S_IDLE);
  assign busy         = !start_ready;
  assign result_valid = done;
  assign result       = done ? res_sh : '0;
  assign flag_n       = done & res_sh[WIDTH-1];
  assign flag_z       = done & zero_acc;
  assign flag_c       = done & carry;
  assign flag_v       = done & (carry_msb ^ carry);

endmodule
